// File: rtl/forward_ctrl.sv
// forward_ctrl: operand forwarding and load-use stall control for a
// single-issue pipeline with an EX stage followed by two history stages.
//
// S1 holds the instruction that left EX one cycle ago and S2 holds the one
// that left two cycles ago. The ALU operand muxes are steered toward the
// youngest producer of each source register. A load sitting in S1 has no
// data yet, so a dependent EX instruction is held for one cycle. During
// that cycle the load moves into S2 carrying mem_rdata.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid              an instruction occupies EX
//   ex_rs1/rs2_addr       EX source register indices
//   ex_use_rs1/rs2        EX instruction reads rs1 / rs2
//   ex_a_pc, ex_b_imm     operand A is the PC / operand B is the immediate
//   ex_rd_addr, ex_rd_we  EX destination index and write enable
//   ex_is_load            EX instruction is a load
//   alu_result            ALU output for the EX instruction
//   mem_rdata             load data for the load currently in S1
//   a_sel, b_sel          00 register, 01 pc/imm, 10 next_rd, 11 next_next_rd
//   next_rd               S1 value (registered)
//   next_next_rd          S2 value (registered)
//   stall                 load-use hazard; EX is held this cycle
//   stall_count           saturating count of stall cycles
module forward_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rs1_addr,
  input  logic [4:0]       ex_rs2_addr,
  input  logic             ex_use_rs1,
  input  logic             ex_use_rs2,
  input  logic             ex_a_pc,
  input  logic             ex_b_imm,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_we,
  input  logic             ex_is_load,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_rdata,
  output logic [1:0]       a_sel,
  output logic [1:0]       b_sel,
  output logic [31:0]      next_rd,
  output logic [31:0]      next_next_rd,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_ALT = 2'b01;
  localparam logic [1:0] SEL_S1  = 2'b10;
  localparam logic [1:0] SEL_S2  = 2'b11;

  // S1 history entry
  logic             s1_valid_q, s1_valid_d;
  logic [4:0]       s1_rd_addr_q, s1_rd_addr_d;
  logic             s1_rd_we_q, s1_rd_we_d;
  logic             s1_is_load_q, s1_is_load_d;
  logic [31:0]      s1_value_q, s1_value_d;

  // S2 history entry. Its load flag is not stored: by the time an entry
  // reaches S2 its value already holds the resolved load data.
  logic             s2_valid_q, s2_valid_d;
  logic [4:0]       s2_rd_addr_q, s2_rd_addr_d;
  logic             s2_rd_we_q, s2_rd_we_d;
  logic [31:0]      s2_value_q, s2_value_d;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic s1_hit_rs1, s1_hit_rs2, s2_hit_rs1, s2_hit_rs2;

  // Pick an operand source. The pc/immediate override wins over any
  // forwarding, and S1 beats S2 because it is the younger producer.
  function automatic logic [1:0] pick_sel(input logic valid, input logic override,
                                          input logic use_r, input logic hit1,
                                          input logic hit2);
    logic [1:0] sel;
    sel = SEL_REG;
    if (!valid)               sel = SEL_REG;
    else if (override)        sel = SEL_ALT;
    else if (use_r && hit1)   sel = SEL_S1;
    else if (use_r && hit2)   sel = SEL_S2;
    return sel;
  endfunction

  // A history entry only produces a register when it is valid and writing.
  // x0 is hard-wired to zero, so it is never a forwarding target.
  always_comb begin
    s1_hit_rs1 = s1_valid_q && s1_rd_we_q && (s1_rd_addr_q == ex_rs1_addr) && (ex_rs1_addr != 5'd0);
    s1_hit_rs2 = s1_valid_q && s1_rd_we_q && (s1_rd_addr_q == ex_rs2_addr) && (ex_rs2_addr != 5'd0);
    s2_hit_rs1 = s2_valid_q && s2_rd_we_q && (s2_rd_addr_q == ex_rs1_addr) && (ex_rs1_addr != 5'd0);
    s2_hit_rs2 = s2_valid_q && s2_rd_we_q && (s2_rd_addr_q == ex_rs2_addr) && (ex_rs2_addr != 5'd0);
  end

  // Selects and the load-use stall. An operand replaced by pc/imm does not
  // need the load result, so it cannot cause a stall.
  always_comb begin
    a_sel = pick_sel(ex_valid, ex_a_pc, ex_use_rs1, s1_hit_rs1, s2_hit_rs1);
    b_sel = pick_sel(ex_valid, ex_b_imm, ex_use_rs2, s1_hit_rs2, s2_hit_rs2);
    stall = ex_valid && s1_is_load_q &&
            ((ex_use_rs1 && !ex_a_pc && s1_hit_rs1) ||
             (ex_use_rs2 && !ex_b_imm && s1_hit_rs2));
  end

  // Next-state for the history pipe. S1 always ages into S2, and a load
  // picks up mem_rdata on the way. When stalled, S1 becomes a bubble and
  // EX is not captured because upstream presents it again next cycle.
  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_rd_addr_d  = s1_rd_addr_q;
    s2_rd_we_d    = s1_rd_we_q;
    s2_value_d    = s1_is_load_q ? mem_rdata : s1_value_q;

    s1_valid_d    = ex_valid;
    s1_rd_addr_d  = ex_rd_addr;
    s1_rd_we_d    = ex_rd_we;
    s1_is_load_d  = ex_is_load;
    s1_value_d    = alu_result;

    stall_count_d = stall_count_q;

    if (stall) begin
      s1_valid_d   = 1'b0;
      s1_rd_addr_d = s1_rd_addr_q;
      s1_rd_we_d   = s1_rd_we_q;
      s1_is_load_d = s1_is_load_q;
      s1_value_d   = s1_value_q;
      if (stall_count_q != {CNT_W{1'b1}}) begin
        stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // State registers. Reset clears both valid bits, which also drops any
  // pending hazard, so the first instruction after reset sees no history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_rd_addr_q  <= 5'd0;
      s1_rd_we_q    <= 1'b0;
      s1_is_load_q  <= 1'b0;
      s1_value_q    <= 32'd0;
      s2_valid_q    <= 1'b0;
      s2_rd_addr_q  <= 5'd0;
      s2_rd_we_q    <= 1'b0;
      s2_value_q    <= 32'd0;
      stall_count_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_rd_addr_q  <= s1_rd_addr_d;
      s1_rd_we_q    <= s1_rd_we_d;
      s1_is_load_q  <= s1_is_load_d;
      s1_value_q    <= s1_value_d;
      s2_valid_q    <= s2_valid_d;
      s2_rd_addr_q  <= s2_rd_addr_d;
      s2_rd_we_q    <= s2_rd_we_d;
      s2_value_q    <= s2_value_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign next_rd      = s1_value_q;
  assign next_next_rd = s2_value_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed scenarios followed by randomized traffic for
// forward_ctrl. A reference model tracks the two most recent instructions
// that left EX and derives selects, stall, values and the stall count.
module tb_forward_ctrl;

  localparam int CW     = 4;
  localparam int CNTMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid, ex_use_rs1, ex_use_rs2, ex_a_pc, ex_b_imm;
  logic          ex_rd_we, ex_is_load;
  logic [4:0]    ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [31:0]   alu_result, mem_rdata;
  logic [1:0]    a_sel, b_sel;
  logic [31:0]   next_rd, next_next_rd;
  logic          stall;
  logic [CW-1:0] stall_count;

  forward_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
    .ex_a_pc(ex_a_pc), .ex_b_imm(ex_b_imm),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .alu_result(alu_result), .mem_rdata(mem_rdata),
    .a_sel(a_sel), .b_sel(b_sel), .next_rd(next_rd), .next_next_rd(next_next_rd),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // One retired instruction as seen by the model. 'known' marks that the
  // stored value is defined (valid entry, reset value, or non-load bubble).
  typedef struct packed {
    logic        valid;
    logic        rd_we;
    logic        is_load;
    logic        known;
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  ent_t h1, h2;
  int   exp_cnt;
  int   tests = 0;
  int   fails = 0;
  logic last_stall = 1'b0;

  function automatic logic hits(input ent_t e, input logic [4:0] r);
    return e.valid && e.rd_we && (e.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] exp_sel(input logic ovr, input logic use_r, input logic [4:0] r);
    if (!ex_valid) return 2'd0;
    if (ovr) return 2'd1;
    if (use_r && hits(h1, r)) return 2'd2;
    if (use_r && hits(h2, r)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic exp_stall();
    return ex_valid && h1.valid && h1.is_load &&
           ((ex_use_rs1 && !ex_a_pc && hits(h1, ex_rs1_addr)) ||
            (ex_use_rs2 && !ex_b_imm && hits(h1, ex_rs2_addr)));
  endfunction

  task automatic modelReset();
    h1 = '0; h1.known = 1'b1;
    h2 = '0; h2.known = 1'b1;
    exp_cnt = 0;
  endtask

  // Single comparison point: counts the test and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic checkModel();
    checkOutput("a_sel", 32'(a_sel), 32'(exp_sel(ex_a_pc, ex_use_rs1, ex_rs1_addr)));
    checkOutput("b_sel", 32'(b_sel), 32'(exp_sel(ex_b_imm, ex_use_rs2, ex_rs2_addr)));
    checkOutput("stall", 32'(stall), 32'(exp_stall()));
    checkOutput("stall_count", 32'(stall_count), 32'(exp_cnt));
    if (h1.known) checkOutput("next_rd", next_rd, h1.val);
    if (h2.known) checkOutput("next_next_rd", next_next_rd, h2.val);
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic apc, input logic bimm,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic [31:0] alu, input logic [31:0] mem);
    ex_valid = v; ex_rs1_addr = rs1; ex_rs2_addr = rs2;
    ex_use_rs1 = u1; ex_use_rs2 = u2; ex_a_pc = apc; ex_b_imm = bimm;
    ex_rd_addr = rd; ex_rd_we = we; ex_is_load = ld;
    alu_result = alu; mem_rdata = mem;
  endtask

  // Age the model by one cycle, then let the clock edge happen.
  task automatic advance();
    ent_t n1, n2;
    logic st;
    st = exp_stall();
    n2 = h1;
    n2.val = h1.is_load ? mem_rdata : h1.val;
    n2.known = h1.valid || (h1.known && !h1.is_load);
    if (st) begin
      n1 = h1;
      n1.valid = 1'b0;
      if (exp_cnt < CNTMAX) exp_cnt++;
    end else begin
      n1.valid = ex_valid; n1.rd_we = ex_rd_we; n1.is_load = ex_is_load;
      n1.known = 1'b1; n1.rd = ex_rd_addr; n1.val = alu_result;
    end
    last_stall = st;
    @(posedge clk);
    h1 = n1;
    h2 = n2;
    #1;
  endtask

  task automatic step();
    #1;
    checkModel();
    advance();
  endtask

  initial begin
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic        r_u1, r_u2, r_apc, r_bimm, r_we, r_ld, r_v;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    modelReset();
    #2;
    checkOutput("rst_next_rd", next_rd, 32'h0);
    checkOutput("rst_next_next_rd", next_next_rd, 32'h0);
    checkOutput("rst_stall_count", 32'(stall_count), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x5,x0,7 ; add x6,x5,x5
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 5, 1, 0, 32'd7, 32'h0);
    step();
    applyStimulus(1, 5, 5, 1, 1, 0, 0, 6, 1, 0, 32'd14, 32'h0);
    #1;
    checkOutput("b2b_a_sel", 32'(a_sel), 32'd2);
    checkOutput("b2b_b_sel", 32'(b_sel), 32'd2);
    checkOutput("b2b_next_rd", next_rd, 32'd7);
    checkOutput("b2b_stall", 32'(stall), 32'd0);
    step();

    // addi x5=3 ; addi x10 ; sub x7,x5,x1
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 5, 1, 0, 32'd3, 32'h0);
    step();
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 10, 1, 0, 32'd1, 32'h0);
    step();
    applyStimulus(1, 5, 1, 1, 1, 0, 0, 7, 1, 0, 32'd2, 32'h0);
    #1;
    checkOutput("s2_a_sel", 32'(a_sel), 32'd3);
    checkOutput("s2_b_sel", 32'(b_sel), 32'd0);
    checkOutput("s2_next_next_rd", next_next_rd, 32'd3);
    step();

    // lw x8 ; add x9,x8,x2 with one stall cycle
    applyStimulus(1, 2, 0, 1, 0, 0, 1, 8, 1, 1, 32'h100, 32'h0);
    step();
    applyStimulus(1, 8, 2, 1, 1, 0, 0, 9, 1, 0, 32'h55, 32'hDEADBEEF);
    #1;
    checkOutput("lu_stall", 32'(stall), 32'd1);
    checkOutput("lu_cnt0", 32'(stall_count), 32'd0);
    checkModel();
    advance();
    applyStimulus(1, 8, 2, 1, 1, 0, 0, 9, 1, 0, 32'h66, 32'h12345678);
    #1;
    checkOutput("lu_cnt1", 32'(stall_count), 32'd1);
    checkOutput("lu_a_sel", 32'(a_sel), 32'd3);
    checkOutput("lu_next_next_rd", next_next_rd, 32'hDEADBEEF);
    checkOutput("lu_stall_clear", 32'(stall), 32'd0);
    step();

    // x0 and rd_we=0 never forward; S1 beats S2 on x4
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd9, 32'h0);
    step();
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 11, 1, 0, 32'd0, 32'h0);
    #1;
    checkOutput("x0_a_sel", 32'(a_sel), 32'd0);
    checkOutput("x0_b_sel", 32'(b_sel), 32'd0);
    step();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 32'd8, 32'h0);
    step();
    applyStimulus(1, 4, 4, 1, 1, 0, 0, 12, 0, 0, 32'd0, 32'h0);
    #1;
    checkOutput("nowe_a_sel", 32'(a_sel), 32'd0);
    checkOutput("nowe_b_sel", 32'(b_sel), 32'd0);
    step();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 4, 1, 0, 32'd1, 32'h0);
    step();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 4, 1, 0, 32'd2, 32'h0);
    step();
    applyStimulus(1, 4, 4, 1, 1, 0, 0, 13, 1, 0, 32'd3, 32'h0);
    #1;
    checkOutput("prio_a_sel", 32'(a_sel), 32'd2);
    checkOutput("prio_next_rd", next_rd, 32'd2);
    checkOutput("prio_next_next_rd", next_next_rd, 32'd1);
    step();

    // Overrides hide a matching load in S1
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 12, 1, 1, 32'h200, 32'h0);
    step();
    applyStimulus(1, 12, 12, 1, 1, 1, 1, 14, 1, 0, 32'h44, 32'hAAAA5555);
    #1;
    checkOutput("ovr_a_sel", 32'(a_sel), 32'd1);
    checkOutput("ovr_b_sel", 32'(b_sel), 32'd1);
    checkOutput("ovr_stall", 32'(stall), 32'd0);
    step();

    // Reset pulsed during a stall
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 13, 1, 1, 32'h300, 32'h0);
    step();
    applyStimulus(1, 13, 0, 1, 0, 0, 1, 15, 1, 0, 32'h77, 32'hCAFEF00D);
    #1;
    checkOutput("rstmid_stall_pre", 32'(stall), 32'd1);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rstmid_next_rd", next_rd, 32'h0);
    checkOutput("rstmid_next_next_rd", next_next_rd, 32'h0);
    checkOutput("rstmid_cnt", 32'(stall_count), 32'h0);
    checkOutput("rstmid_stall", 32'(stall), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rstpost_a_sel", 32'(a_sel), 32'd0);
    checkModel();
    advance();

    // Repeated load-use pairs drive the counter into saturation
    for (int i = 0; i < CNTMAX + 3; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 0, 1, 14, 1, 1, 32'h400 + 32'(i), 32'h0);
      step();
      applyStimulus(1, 14, 0, 1, 0, 0, 1, 16, 1, 0, 32'h1, $urandom);
      step();
      applyStimulus(1, 14, 0, 1, 0, 0, 1, 16, 1, 0, 32'h2, $urandom);
      step();
    end
    #1;
    checkOutput("sat_cnt", 32'(stall_count), 32'(CNTMAX));

    // Randomized traffic on a small register window to provoke hazards
    r_v = 0; r_rs1 = 0; r_rs2 = 0; r_u1 = 0; r_u2 = 0; r_apc = 0; r_bimm = 0;
    r_rd = 0; r_we = 0; r_ld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        r_v    = ($urandom_range(7) != 0);
        r_rs1  = 5'($urandom_range(3));
        r_rs2  = 5'($urandom_range(3));
        r_u1   = 1'($urandom_range(1));
        r_u2   = 1'($urandom_range(1));
        r_apc  = ($urandom_range(3) == 0);
        r_bimm = ($urandom_range(3) == 0);
        r_rd   = 5'($urandom_range(3));
        r_we   = ($urandom_range(3) != 0);
        r_ld   = ($urandom_range(2) == 0);
      end
      applyStimulus(r_v, r_rs1, r_rs2, r_u1, r_u2, r_apc, r_bimm, r_rd, r_we, r_ld,
                    $urandom, $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
